// File: rtl/ej32_mem_arb_if.sv
// Bus bundle between the eJ32 core, the host DMA port and the RAM macro.
// The arbiter masters the RAM; the core/host/RAM environment is the slave side.
interface ej32_mem_arb_if #(
  parameter int ASZ = 17,
  parameter int LSZ = 4
);
  logic [ASZ-1:0] pc_addr;
  logic           ls_asel;
  logic [ASZ-1:0] ls_addr;
  logic [7:0]     ls_data;
  logic           ls_we;
  logic           core_idle;
  logic           hreq;
  logic           hwe;
  logic [ASZ-1:0] haddr;
  logic [LSZ-1:0] hlen;
  logic [7:0]     hwdata;
  logic           hgnt;
  logic           hnext;
  logic [7:0]     hrdata;
  logic           hrvalid;
  logic           hdone;
  logic           core_stall;
  logic [ASZ-1:0] mem_addr;
  logic [7:0]     mem_wdata;
  logic           mem_we;
  logic [7:0]     mem_rdata;

  modport master (
    input  pc_addr, ls_asel, ls_addr, ls_data, ls_we, core_idle,
           hreq, hwe, haddr, hlen, hwdata, mem_rdata,
    output hgnt, hnext, hrdata, hrvalid, hdone, core_stall,
           mem_addr, mem_wdata, mem_we
  );

  modport slave (
    output pc_addr, ls_asel, ls_addr, ls_data, ls_we, core_idle,
           hreq, hwe, haddr, hlen, hwdata, mem_rdata,
    input  hgnt, hnext, hrdata, hrvalid, hdone, core_stall,
           mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/ej32_mem_arb.sv
// Single-port RAM arbiter for eJ32: core (ls > pc) versus host DMA bursts.
// Host bursts run only at instruction boundaries; the interrupted core address is replayed.
module ej32_mem_arb #(
  parameter int ASZ = 17,
  parameter int LSZ = 4
) (
  input  logic           clk,
  input  logic           rst,
  ej32_mem_arb_if.master bus
);

  localparam logic [1:0] ST_CORE   = 2'd0;
  localparam logic [1:0] ST_HOST   = 2'd1;
  localparam logic [1:0] ST_RESUME = 2'd2;

  logic [1:0]     state;
  logic [ASZ-1:0] hptr;
  logic [ASZ-1:0] sav;
  logic [LSZ-1:0] cnt;
  logic           hw;
  logic [ASZ-1:0] core_addr;
  logic           grant;

  // Core-side address mux and host grant qualification
  always_comb begin
    core_addr = bus.ls_asel ? bus.ls_addr : bus.pc_addr;
    grant     = (state == ST_CORE) & bus.hreq & bus.core_idle & ~bus.ls_asel;
  end

  // Arbiter state, burst pointer/count and replay address
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_CORE;
      hptr        <= {ASZ{1'b0}};
      sav         <= {ASZ{1'b0}};
      cnt         <= {LSZ{1'b0}};
      hw          <= 1'b0;
      bus.hrvalid <= 1'b0;
    end else begin
      bus.hrvalid <= (state == ST_HOST) & ~hw;
      case (state)
        ST_CORE: begin
          if (grant) begin
            hptr  <= bus.haddr;
            cnt   <= bus.hlen;
            hw    <= bus.hwe;
            sav   <= core_addr;
            state <= ST_HOST;
          end
        end
        ST_HOST: begin
          hptr <= hptr + {{(ASZ-1){1'b0}}, 1'b1};
          // Hold at zero on the last beat so the count never wraps into a new burst
          if (cnt == {LSZ{1'b0}}) begin
            state <= ST_RESUME;
          end else begin
            cnt <= cnt - {{(LSZ-1){1'b0}}, 1'b1};
          end
        end
        ST_RESUME: begin
          state <= ST_CORE;
        end
        default: begin
          state <= ST_CORE;
        end
      endcase
    end
  end

  // RAM port steering and state-decoded handshake outputs
  always_comb begin
    bus.mem_addr   = core_addr;
    bus.mem_wdata  = bus.ls_data;
    bus.mem_we     = 1'b0;
    bus.hgnt       = 1'b0;
    bus.hnext      = 1'b0;
    bus.hdone      = 1'b0;
    bus.core_stall = 1'b0;
    case (state)
      ST_CORE: begin
        bus.mem_we = bus.ls_asel & bus.ls_we & ~rst;
      end
      ST_HOST: begin
        bus.mem_addr   = hptr;
        bus.mem_wdata  = bus.hwdata;
        bus.mem_we     = hw & ~rst;
        bus.hgnt       = 1'b1;
        bus.hnext      = 1'b1;
        bus.core_stall = 1'b1;
      end
      ST_RESUME: begin
        // Re-issue the core's address so its byte lands in the first CORE cycle
        bus.mem_addr   = sav;
        bus.hdone      = 1'b1;
        bus.core_stall = 1'b1;
      end
      default: begin
        bus.mem_we = 1'b0;
      end
    endcase
  end

  assign bus.hrdata = bus.mem_rdata;

endmodule

// File: tb/tb_ej32_mem_arb.sv
// Directed bench for ej32_mem_arb: table of CORE-state mux vectors plus
// hand-written burst, wrap, replay and reset-abort sequences against a RAM model.
module tb_ej32_mem_arb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ej32_mem_arb_if #(.ASZ(17), .LSZ(4)) bus ();

  ej32_mem_arb #(.ASZ(17), .LSZ(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0]  ram [0:131071];
  logic        pre_we = 1'b0;
  logic [16:0] pre_addr = 17'h0;
  logic [7:0]  pre_data = 8'h0;

  // synchronous RAM model with a bench-side preload port
  always @(posedge clk) begin
    if (pre_we) ram[pre_addr] <= pre_data;
    else if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  int nvec = 0;
  int nfail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [16:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    tick();
    pre_we   = 1'b0;
  endtask

  typedef struct {
    logic [16:0] pc;
    logic        asel;
    logic [16:0] la;
    logic [7:0]  ld;
    logic        lwe;
    logic        hreq;
    logic        idle;
    logic [16:0] e_addr;
    logic        e_we;
  } vec_t;

  vec_t tbl [7];

  logic [7:0] rd_bytes [4];
  int gcnt, scnt, dcnt;

  initial begin
    tbl[0] = '{17'h00100, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b0, 1'b1, 17'h00100, 1'b0};
    tbl[1] = '{17'h1ABCD, 1'b0, 17'h01234, 8'h55, 1'b0, 1'b0, 1'b1, 17'h1ABCD, 1'b0};
    tbl[2] = '{17'h00100, 1'b1, 17'h01000, 8'h41, 1'b1, 1'b1, 1'b1, 17'h01000, 1'b1};
    tbl[3] = '{17'h00104, 1'b1, 17'h0FFFF, 8'h7E, 1'b0, 1'b1, 1'b1, 17'h0FFFF, 1'b0};
    tbl[4] = '{17'h00108, 1'b1, 17'h1FFFF, 8'hC3, 1'b1, 1'b0, 1'b0, 17'h1FFFF, 1'b1};
    tbl[5] = '{17'h00300, 1'b0, 17'h00000, 8'h00, 1'b0, 1'b1, 1'b0, 17'h00300, 1'b0};
    tbl[6] = '{17'h00042, 1'b0, 17'h00777, 8'h99, 1'b1, 1'b0, 1'b1, 17'h00042, 1'b0};
    rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; rd_bytes[3] = 8'h44;

    bus.pc_addr = 17'h00100; bus.ls_asel = 1'b1; bus.ls_addr = 17'h00ABC;
    bus.ls_data = 8'h00; bus.ls_we = 1'b1; bus.core_idle = 1'b1;
    bus.hreq = 1'b0; bus.hwe = 1'b0; bus.haddr = 17'h01400; bus.hlen = 4'd3;
    bus.hwdata = 8'h00;

    // reset: preload RAM while a LS write is attempted (must be suppressed)
    tick();
    preload(17'h01400, 8'h11);
    preload(17'h01401, 8'h22);
    preload(17'h01402, 8'h33);
    preload(17'h01403, 8'h44);
    preload(17'h00555, 8'h66);
    preload(17'h00200, 8'h5A);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", {15'd0, bus.mem_addr}, 32'h00ABC);
    chk("rst_hgnt", {31'd0, bus.hgnt}, 32'd0);
    chk("rst_hnext", {31'd0, bus.hnext}, 32'd0);
    chk("rst_hrvalid", {31'd0, bus.hrvalid}, 32'd0);
    chk("rst_hdone", {31'd0, bus.hdone}, 32'd0);
    chk("rst_stall", {31'd0, bus.core_stall}, 32'd0);
    rst = 1'b0;
    bus.ls_asel = 1'b0; bus.ls_we = 1'b0;
    #1;
    chk("idle_mem_addr", {15'd0, bus.mem_addr}, 32'h00100);

    // CORE-state mux vectors, none of which may produce a grant
    for (int i = 0; i < 7; i++) begin
      bus.pc_addr = tbl[i].pc; bus.ls_asel = tbl[i].asel; bus.ls_addr = tbl[i].la;
      bus.ls_data = tbl[i].ld; bus.ls_we = tbl[i].lwe; bus.hreq = tbl[i].hreq;
      bus.core_idle = tbl[i].idle;
      #1;
      chk($sformatf("v%0d_mem_addr", i), {15'd0, bus.mem_addr}, {15'd0, tbl[i].e_addr});
      chk($sformatf("v%0d_mem_we", i), {31'd0, bus.mem_we}, {31'd0, tbl[i].e_we});
      if (tbl[i].asel) chk($sformatf("v%0d_mem_wdata", i), {24'd0, bus.mem_wdata}, {24'd0, tbl[i].ld});
      chk($sformatf("v%0d_stall", i), {31'd0, bus.core_stall}, 32'd0);
      tick();
      chk($sformatf("v%0d_no_grant", i), {31'd0, bus.hgnt}, 32'd0);
    end

    // LS priority, then host read burst of 4 once ls_asel drops
    bus.pc_addr = 17'h00555; bus.ls_asel = 1'b1; bus.ls_addr = 17'h01000;
    bus.ls_data = 8'h41; bus.ls_we = 1'b1; bus.hreq = 1'b1; bus.core_idle = 1'b1;
    bus.haddr = 17'h01400; bus.hlen = 4'd3; bus.hwe = 1'b0;
    #1;
    chk("lsp_mem_addr", {15'd0, bus.mem_addr}, 32'h01000);
    chk("lsp_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("lsp_mem_wdata", {24'd0, bus.mem_wdata}, 32'h41);
    tick();
    chk("lsp_held_off", {31'd0, bus.hgnt}, 32'd0);
    bus.ls_asel = 1'b0; bus.ls_we = 1'b0;
    #1;
    chk("grant_cycle_addr", {15'd0, bus.mem_addr}, 32'h00555);
    tick();
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("rd%0d_hgnt", k), {31'd0, bus.hgnt}, (k < 4) ? 32'd1 : 32'd0);
      chk($sformatf("rd%0d_stall", k), {31'd0, bus.core_stall}, (k < 5) ? 32'd1 : 32'd0);
      chk($sformatf("rd%0d_hrvalid", k), {31'd0, bus.hrvalid}, (k >= 1 && k <= 4) ? 32'd1 : 32'd0);
      chk($sformatf("rd%0d_hdone", k), {31'd0, bus.hdone}, (k == 4) ? 32'd1 : 32'd0);
      if (k < 4) chk($sformatf("rd%0d_mem_addr", k), {15'd0, bus.mem_addr}, 32'h01400 + k);
      if (k >= 1 && k <= 4) chk($sformatf("rd%0d_hrdata", k), {24'd0, bus.hrdata}, {24'd0, rd_bytes[k-1]});
      if (k == 4) chk("rd_resume_addr", {15'd0, bus.mem_addr}, 32'h00555);
      if (k == 5) chk("rd_replay_byte", {24'd0, bus.mem_rdata}, 32'h66);
      if (k == 0) begin
        bus.hreq = 1'b0; bus.haddr = 17'h0AAAA; bus.hlen = 4'd0; bus.pc_addr = 17'h00777;
      end
      tick();
    end

    // host write burst across the top of the address space
    bus.hreq = 1'b1; bus.haddr = 17'h1FFFF; bus.hlen = 4'd1; bus.hwe = 1'b1; bus.hwdata = 8'hAA;
    tick();
    bus.hreq = 1'b0;
    #1;
    chk("wr0_hnext", {31'd0, bus.hnext}, 32'd1);
    chk("wr0_mem_addr", {15'd0, bus.mem_addr}, 32'h1FFFF);
    chk("wr0_mem_we", {31'd0, bus.mem_we}, 32'd1);
    chk("wr0_wdata", {24'd0, bus.mem_wdata}, 32'hAA);
    tick();
    bus.hwdata = 8'hBB;
    #1;
    chk("wr1_hnext", {31'd0, bus.hnext}, 32'd1);
    chk("wr1_mem_addr", {15'd0, bus.mem_addr}, 32'h00000);
    chk("wr1_wdata", {24'd0, bus.mem_wdata}, 32'hBB);
    tick();
    chk("wr_hdone", {31'd0, bus.hdone}, 32'd1);
    chk("wr_hnext_off", {31'd0, bus.hnext}, 32'd0);
    chk("wr_resume_we", {31'd0, bus.mem_we}, 32'd0);
    chk("wr_no_hrvalid", {31'd0, bus.hrvalid}, 32'd0);
    tick();
    chk("wr_ram_top", {24'd0, ram[17'h1FFFF]}, 32'hAA);
    chk("wr_ram_zero", {24'd0, ram[17'h00000]}, 32'hBB);

    // single-beat replay; hreq held through RESUME must not re-grant there
    bus.pc_addr = 17'h00200; bus.hreq = 1'b1; bus.haddr = 17'h01402; bus.hlen = 4'd0; bus.hwe = 1'b0;
    tick();
    chk("rp_host", {31'd0, bus.hgnt}, 32'd1);
    tick();
    chk("rp_resume_hdone", {31'd0, bus.hdone}, 32'd1);
    chk("rp_resume_addr", {15'd0, bus.mem_addr}, 32'h00200);
    chk("rp_hrdata", {24'd0, bus.hrdata}, 32'h33);
    tick();
    chk("rp_core_stall", {31'd0, bus.core_stall}, 32'd0);
    chk("rp_no_regrant", {31'd0, bus.hgnt}, 32'd0);
    chk("rp_replay_byte", {24'd0, bus.mem_rdata}, 32'h5A);
    bus.hreq = 1'b0;
    tick();

    // 16-beat burst: count stays bounded to one burst
    bus.hreq = 1'b1; bus.haddr = 17'h01400; bus.hlen = 4'd15; bus.hwe = 1'b0;
    tick();
    bus.hreq = 1'b0;
    gcnt = 0; scnt = 0; dcnt = 0;
    for (int c = 0; c < 40; c++) begin
      gcnt += int'(bus.hgnt);
      scnt += int'(bus.core_stall);
      dcnt += int'(bus.hdone);
      tick();
    end
    chk("b16_hgnt_cycles", gcnt, 32'd16);
    chk("b16_stall_cycles", scnt, 32'd17);
    chk("b16_hdone_pulses", dcnt, 32'd1);

    // reset at beat 2 of an 8-beat burst
    bus.hreq = 1'b1; bus.hlen = 4'd7;
    tick();
    bus.hreq = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rb_rst_we", {31'd0, bus.mem_we}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rb_hgnt", {31'd0, bus.hgnt}, 32'd0);
    chk("rb_stall", {31'd0, bus.core_stall}, 32'd0);
    chk("rb_hdone", {31'd0, bus.hdone}, 32'd0);
    dcnt = 0;
    for (int c = 0; c < 12; c++) begin
      dcnt += int'(bus.hdone) + int'(bus.hgnt);
      tick();
    end
    chk("rb_quiet_after", dcnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
